// File: rtl/pipe_ir_regs.sv
// Stage-register bank for a 5-stage RV32I pipeline: PC, PC2..PC4, IR2..IR5 and
// performance counters, steered by the hazard/forwarding unit's mux selects.
module pipe_ir_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic [1:0]       select_pc,
    input  logic             select_pc2,
    input  logic [1:0]       select_ir2,
    input  logic [1:0]       select_ir3,
    input  logic             select_ir4,
    input  logic [31:0]      jump_addr,
    input  logic [31:0]      branch_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc2_out,
    output logic [31:0]      pc3_out,
    output logic [31:0]      pc4_out,
    output logic [31:0]      ir2_output,
    output logic [31:0]      ir3_output,
    output logic [31:0]      ir4_output,
    output logic [31:0]      ir5_output,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q,  pc_d;
    logic [31:0]      pc2_q, pc2_d;
    logic [31:0]      pc3_q, pc3_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      ir2_q, ir2_d;
    logic [31:0]      ir3_q, ir3_d;
    logic [31:0]      ir4_q, ir4_d;
    logic [31:0]      ir5_q, ir5_d;
    logic [CNT_W-1:0] cycle_q,  cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0] flush_q,  flush_d;

    // Next-state for stage registers and counters; freeze holds every stage reg.
    always_comb begin
        pc_d     = pc_q;
        pc2_d    = pc2_q;
        pc3_d    = pc3_q;
        pc4_d    = pc4_q;
        ir2_d    = ir2_q;
        ir3_d    = ir3_q;
        ir4_d    = ir4_q;
        ir5_d    = ir5_q;
        cycle_d  = cycle_q + CNT_ONE;
        retire_d = retire_q;
        stall_d  = stall_q;
        flush_d  = flush_q;

        if (!freeze) begin
            case (select_pc)
                2'd0:    pc_d = jump_addr;
                2'd1:    pc_d = pc_q + 32'd4;
                2'd2:    pc_d = pc_q;
                2'd3:    pc_d = branch_addr;
                default: pc_d = pc_q;
            endcase

            if (select_pc2) begin
                pc2_d = pc2_q;
            end else begin
                pc2_d = pc_q;
            end
            pc3_d = pc2_q;
            pc4_d = pc3_q;

            case (select_ir2)
                2'd0:    ir2_d = imem_rdata;
                2'd2:    ir2_d = ir2_q;
                default: ir2_d = NOP_INSN;
            endcase

            case (select_ir3)
                2'd0:    ir3_d = ir2_q;
                default: ir3_d = NOP_INSN;
            endcase

            if (select_ir4) begin
                ir4_d = NOP_INSN;
            end else begin
                ir4_d = ir3_q;
            end
            ir5_d = ir4_q;

            if (ir5_q != NOP_INSN) begin
                retire_d = retire_q + CNT_ONE;
            end else begin
                retire_d = retire_q;
            end

            if (select_pc == 2'd2) begin
                stall_d = stall_q + CNT_ONE;
            end else begin
                stall_d = stall_q;
            end

            if ((select_pc == 2'd0) || (select_pc == 2'd3)) begin
                flush_d = flush_q + CNT_ONE;
            end else begin
                flush_d = flush_q;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Stage and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            pc2_q    <= RESET_PC;
            pc3_q    <= RESET_PC;
            pc4_q    <= RESET_PC;
            ir2_q    <= NOP_INSN;
            ir3_q    <= NOP_INSN;
            ir4_q    <= NOP_INSN;
            ir5_q    <= NOP_INSN;
            cycle_q  <= {CNT_W{1'b0}};
            retire_q <= {CNT_W{1'b0}};
            stall_q  <= {CNT_W{1'b0}};
            flush_q  <= {CNT_W{1'b0}};
        end else begin
            pc_q     <= pc_d;
            pc2_q    <= pc2_d;
            pc3_q    <= pc3_d;
            pc4_q    <= pc4_d;
            ir2_q    <= ir2_d;
            ir3_q    <= ir3_d;
            ir4_q    <= ir4_d;
            ir5_q    <= ir5_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign pc2_out    = pc2_q;
    assign pc3_out    = pc3_q;
    assign pc4_out    = pc4_q;
    assign ir2_output = ir2_q;
    assign ir3_output = ir3_q;
    assign ir4_output = ir4_q;
    assign ir5_output = ir5_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_ir_regs.sv
// Directed bench for pipe_ir_regs: fetch, stall, redirect, freeze, PC wrap, async reset.
module tb_pipe_ir_regs;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic [1:0]  select_pc;
    logic        select_pc2;
    logic [1:0]  select_ir2;
    logic [1:0]  select_ir3;
    logic        select_ir4;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc_out, pc2_out, pc3_out, pc4_out;
    logic [31:0] ir2_output, ir3_output, ir4_output, ir5_output;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory model: address-tagged words.
    assign imem_rdata = imem_addr ^ TAG;

    pipe_ir_regs dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .select_pc(select_pc), .select_pc2(select_pc2),
        .select_ir2(select_ir2), .select_ir3(select_ir3), .select_ir4(select_ir4),
        .jump_addr(jump_addr), .branch_addr(branch_addr),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .pc_out(pc_out), .pc2_out(pc2_out), .pc3_out(pc3_out), .pc4_out(pc4_out),
        .ir2_output(ir2_output), .ir3_output(ir3_output),
        .ir4_output(ir4_output), .ir5_output(ir5_output),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_normal();
        freeze = 1'b0; select_pc = 2'd1; select_pc2 = 1'b0;
        select_ir2 = 2'd0; select_ir3 = 2'd0; select_ir4 = 1'b0;
    endtask

    task automatic sel_stall();
        freeze = 1'b0; select_pc = 2'd2; select_pc2 = 1'b1;
        select_ir2 = 2'd2; select_ir3 = 2'd1; select_ir4 = 1'b0;
    endtask

    task automatic sel_redirect(input logic [1:0] sp);
        select_pc = sp; select_pc2 = 1'b0;
        select_ir2 = 2'd1; select_ir3 = 2'd1; select_ir4 = 1'b1;
    endtask

    initial begin
        reset = 1'b1; jump_addr = 32'h0; branch_addr = 32'h0;
        sel_normal();
        #12;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ir5", ir5_output, NOP);
        chk("rst_cycle", cycle_cnt, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain fetch
        step();
        chk("e1_pc", pc_out, 32'h4);
        chk("e1_ir2", ir2_output, TAG ^ 32'h0);
        chk("e1_ir3", ir3_output, NOP);
        step();
        chk("e2_pc", pc_out, 32'h8);
        chk("e2_ir3", ir3_output, TAG ^ 32'h0);
        chk("e2_pc2", pc2_out, 32'h4);

        // Load-use stall at PC=8
        sel_stall();
        step();
        chk("st_pc", pc_out, 32'h8);
        chk("st_imem_addr", imem_addr, 32'h8);
        chk("st_ir2", ir2_output, TAG ^ 32'h4);
        chk("st_ir3", ir3_output, NOP);
        chk("st_ir4", ir4_output, TAG ^ 32'h0);
        chk("st_pc2", pc2_out, 32'h4);
        chk("st_cnt", stall_cnt, 32'd1);

        sel_normal();
        step();
        chk("e4_pc", pc_out, 32'hC);
        chk("e4_ir2", ir2_output, TAG ^ 32'h8);
        chk("e4_ir3", ir3_output, TAG ^ 32'h4);
        chk("e4_ir5", ir5_output, TAG ^ 32'h0);
        chk("e4_retire", retire_cnt, 32'd0);
        step();
        chk("e5_retire", retire_cnt, 32'd1);
        chk("e5_ir4", ir4_output, TAG ^ 32'h4);
        chk("e5_cycle", cycle_cnt, 32'd5);

        // Jump redirect
        jump_addr = 32'h100;
        sel_redirect(2'd0);
        step();
        chk("jmp_pc", pc_out, 32'h100);
        chk("jmp_ir2", ir2_output, NOP);
        chk("jmp_ir3", ir3_output, NOP);
        chk("jmp_ir4", ir4_output, NOP);
        chk("jmp_ir5", ir5_output, TAG ^ 32'h4);
        chk("jmp_flush", flush_cnt, 32'd1);

        // Branch held off by freeze for two cycles
        branch_addr = 32'h40;
        sel_redirect(2'd3);
        freeze = 1'b1;
        step();
        step();
        chk("frz_pc", pc_out, 32'h100);
        chk("frz_ir5", ir5_output, TAG ^ 32'h4);
        chk("frz_cycle", cycle_cnt, 32'd8);
        chk("frz_flush", flush_cnt, 32'd1);
        chk("frz_retire", retire_cnt, 32'd1);
        freeze = 1'b0;
        step();
        chk("br_pc", pc_out, 32'h40);
        chk("br_flush", flush_cnt, 32'd2);
        chk("br_retire", retire_cnt, 32'd2);
        chk("br_ir5", ir5_output, NOP);

        sel_normal();
        step();
        chk("br_fetch_pc", pc_out, 32'h44);
        chk("br_fetch_ir2", ir2_output, TAG ^ 32'h40);

        // PC+4 wrap
        jump_addr = 32'hFFFF_FFFC;
        sel_redirect(2'd0);
        step();
        chk("wr_pc", pc_out, 32'hFFFF_FFFC);
        sel_normal();
        step();
        chk("wr_pc0", pc_out, 32'h0);
        chk("wr_ir2", ir2_output, 32'h3F21_FFFC);
        chk("wr_flush", flush_cnt, 32'd3);

        // Asynchronous reset during a stall
        sel_stall();
        step();
        chk("st2_cnt", stall_cnt, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pc", pc_out, 32'h0);
        chk("ar_pc4", pc4_out, 32'h0);
        chk("ar_ir2", ir2_output, NOP);
        chk("ar_ir3", ir3_output, NOP);
        chk("ar_ir4", ir4_output, NOP);
        chk("ar_ir5", ir5_output, NOP);
        chk("ar_cycle", cycle_cnt, 32'd0);
        chk("ar_retire", retire_cnt, 32'd0);
        chk("ar_stall", stall_cnt, 32'd0);
        chk("ar_flush", flush_cnt, 32'd0);
        sel_normal();
        #1;
        reset = 1'b0;
        step();
        chk("post_pc", pc_out, 32'h4);
        chk("post_ir2", ir2_output, TAG ^ 32'h0);
        chk("post_cycle", cycle_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
